symbol_entry: RTL

//   Front-end input stage for the 5-symbol pattern matcher. Synchronises raw

---
 rtl/match_pkg.sv | 15 +
 rtl/sync_2ff.sv | 27 ++
 rtl/symbol_entry.sv | 137 +++++++++++++
 3 files changed

// File: rtl/match_pkg.sv
// Shared types and sizes for the 5-symbol pattern matcher and its input stage.
package match_pkg;

    localparam int SYM_W   = 3;
    localparam int SEQ_LEN = 5;
    localparam int CNT_W   = $clog2(SEQ_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REL_WAIT
    } deb_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bundle of asynchronous level inputs.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/symbol_entry.sv
// Debounced symbol entry: one set_o strobe per clean press with the switch value
// captured, a saturating symbol count and an idle-timeout clear pulse.
module symbol_entry
    import match_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             btn_set_i,
    input  logic [SYM_W-1:0] sw_data_i,
    output logic             set_o,
    output logic [SYM_W-1:0] data_o,
    output logic [2:0]       count_o,
    output logic             timeout_o
);

    localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic             btn_s;
    logic [SYM_W-1:0] sw_s;

    sync_2ff #(.W(SYM_W + 1)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   ({btn_set_i, sw_data_i}),
        .q_o   ({btn_s, sw_s})
    );

    deb_state_t       state_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             set_q;
    logic [SYM_W-1:0] data_q;
    logic             deb_done;
    logic             accept;

    assign deb_done = (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1));
    assign accept   = (state_q == PRESS_WAIT) && btn_s && deb_done;

    // Reset lands in REL_WAIT so a button held through reset must be released first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= REL_WAIT;
            deb_cnt_q <= '0;
            set_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            set_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (btn_s) begin
                        state_q   <= PRESS_WAIT;
                        deb_cnt_q <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state_q   <= IDLE;
                        deb_cnt_q <= '0;
                    end else if (deb_done) begin
                        state_q   <= PRESSED;
                        deb_cnt_q <= '0;
                        set_q     <= 1'b1;
                        data_q    <= sw_s;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_s) begin
                        state_q   <= REL_WAIT;
                        deb_cnt_q <= '0;
                    end
                end
                REL_WAIT: begin
                    if (btn_s) begin
                        state_q   <= PRESSED;
                        deb_cnt_q <= '0;
                    end else if (deb_done) begin
                        state_q   <= IDLE;
                        deb_cnt_q <= '0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
                    end
                end
                default: begin
                    state_q   <= REL_WAIT;
                    deb_cnt_q <= '0;
                end
            endcase
        end
    end

    logic [CNT_W-1:0] count_q, count_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic             timeout_q, timeout_d;

    // A press accepted on the expiry cycle takes priority over the timeout.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        count_d   = count_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        if (accept) begin
            timer_d = '0;
            if (count_q != CNT_W'(SEQ_LEN)) count_d = count_q + CNT_W'(1);
        end else if (count_q == '0) begin
            timer_d = '0;
        end else if (timer_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            count_d   = '0;
            timer_d   = '0;
        end else begin
            timer_d = timer_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            timer_q   <= timer_d;
            timeout_q <= timeout_d;
        end
    end

    assign set_o     = set_q;
    assign data_o    = data_q;
    assign count_o   = count_q;
    assign timeout_o = timeout_q;

endmodule
